sw_value_capture: RTL and testbench
===================================

# sw_value_capture

Input-side front end for the LED/value datapath: samples eight board switches and two push-buttons, debounces the buttons, and assembles four switch bytes into a 32-bit word. It emits the word as `value` with a one-cycle `enable` strobe, the exact pair the LED-driving counter block consumes. It sits between the board pins and that block in the top level.

## Interface
- `DEBOUNCE_CYCLES`, default 16: consecutive stable synchronized cycles required before a button level is accepted; legal range 2..65535.
- `CLK`  in  1  sole clock; all logic rising-edge.
- `RST`  in  1  reset, synchronous, active-high.
- `sw`  in  8  raw asynchronous switch levels.
- `btn_load`  in  1  raw asynchronous push-button; each debounced press captures one byte.
- `btn_clr`  in  1  raw asynchronous push-button; each debounced press discards the partial word.
- `value`  out  32  last completed word; byte k in bits [8k+7:8k].
- `enable`  out  1  one-cycle strobe, high in the first cycle a new `value` is presented.
- `byte_cnt`  out  2  number of bytes captured into the current partial word.

## Operation
- Synchronization: `sw`, `btn_load` and `btn_clr` each pass through two flops before use.
- Debounce, per button:
  - Keep a debounced level `db` and a counter.
  - If the synchronized level differs from `db`, increment the counter; on reaching DEBOUNCE_CYCLES-1, set `db` to the synchronized level and clear the counter.
  - If the levels are equal, clear the counter.
  - A registered rising-edge detect on `db` produces a one-cycle `press` pulse. Falling edges produce nothing.
- Packing state is held in `byte_cnt` (0..3) and a 24-bit partial register.
  - On a load press with `byte_cnt` < 3: write synchronized `sw` into byte slot `byte_cnt` of the partial register, then `byte_cnt`++.
  - On a load press with `byte_cnt` = 3: `value` <= {sw_sync, partial[23:0]}; `enable` <= 1; `byte_cnt` <= 0.
  - On a clear press: `byte_cnt` <= 0. Partial contents are don't-care. `value` is unchanged, and `enable` is not asserted.
- Load press and clear press in the same cycle: clear wins. The byte is dropped and no strobe is produced.
- `value` holds its contents until the next completed word. `enable` is 0 in every other cycle.
- The byte written is the synchronized `sw` sampled in the same cycle as the press pulse.

## Timing
- Reset values: `value` = 0, `enable` = 0, `byte_cnt` = 0. Sync flops, `db` levels, debounce counters and edge-detect registers are all 0.
- Press latency: raw button held high, first sampled at edge E. Then `db` rises at edge E+1+DEBOUNCE_CYCLES, and `press` is high for the cycle following edge E+2+DEBOUNCE_CYCLES.
- `byte_cnt` and `value`/`enable` update one edge after the press cycle. Total from E to `enable` high: DEBOUNCE_CYCLES+3 edges.
- Glitch rejection: a bounce shorter than DEBOUNCE_CYCLES synchronized cycles clears the counter and produces no press. The same applies to release bounces.
- Holding a button produces exactly one press. A new press requires `db` to return to 0 and rise again.
- Reset asserted mid-word or mid-debounce: the next edge restores all reset values. A button still held after reset is released becomes a fresh press after a full debounce.
- `sw` must be stable for two cycles before the press pulse for a deterministic capture. The block adds no extra guard.

## Structure
- Shared package holds:
  - `BYTES_PER_WORD` = 4
  - `SYNC_STAGES` = 2
  - the default `DEBOUNCE_CYCLES`
  - the `byte_cnt` width constant
- One sub-module, `debounce_pulse`, instantiated twice (load, clear):
  - parameter: `DEBOUNCE_CYCLES`
  - ports: `CLK`, `RST`, `raw`, `level`, `press`
  - contains its own two-flop synchronizer, the counter, and the edge detect.
- The top module holds the `sw` synchronizer, `byte_cnt`, the partial register, `value` and `enable`.

## Test plan
- Use DEBOUNCE_CYCLES = 4 throughout. Reset for 3 cycles, then release; all outputs must read 0 and stay 0 with no button activity.
- Four clean load presses with `sw` = 0x11, 0x22, 0x33, 0x44 -> `byte_cnt` steps 1, 2, 3, 0; `value` = 0x44332211; `enable` high exactly 1 cycle, 7 edges after the 4th press starts.
- Load button bouncing (1-, 2-, 3-cycle highs) before a stable high -> exactly one byte captured.
- Two bytes loaded, clear pressed, then four bytes 0xA0..0xA3 -> `value` = 0xA3A2A1A0; the earlier `value` is unchanged until then, and no strobe comes from the clear.
- Load and clear pressed in the same cycle at `byte_cnt` = 3 -> `byte_cnt` = 0, no `enable`, `value` unchanged.
- `RST` asserted with `byte_cnt` = 2 and the load button mid-debounce -> all outputs 0 next edge; held button yields no press until released and re-pressed.

Source files
------------

// File: rtl/sw_value_capture_pkg.sv
// Shared constants for the switch/button value capture front end.
package sw_value_capture_pkg;

   localparam int unsigned BYTES_PER_WORD      = 4;
   localparam int unsigned SYNC_STAGES         = 2;
   localparam int unsigned DEBOUNCE_CYCLES_DEF = 16;
   localparam int unsigned BYTE_W              = 8;
   localparam int unsigned WORD_W              = BYTE_W * BYTES_PER_WORD;
   localparam int unsigned PARTIAL_W           = BYTE_W * (BYTES_PER_WORD - 1);
   localparam int unsigned BYTE_CNT_W          = $clog2(BYTES_PER_WORD);

endpackage : sw_value_capture_pkg

// File: rtl/sw_value_capture_if.sv
// Board-side inputs and the value/enable pair handed to the LED counter block.
interface sw_value_capture_if;
   import sw_value_capture_pkg::*;

   logic [BYTE_W-1:0]     sw;
   logic                  btn_load;
   logic                  btn_clr;
   logic [WORD_W-1:0]     value;
   logic                  enable;
   logic [BYTE_CNT_W-1:0] byte_cnt;

   modport master (output sw, btn_load, btn_clr, input value, enable, byte_cnt);
   modport slave  (input sw, btn_load, btn_clr, output value, enable, byte_cnt);

endinterface : sw_value_capture_if

// File: rtl/sw_value_capture_debounce_pulse.sv
// Synchronizes one raw button, debounces it and emits a one-cycle pulse per press.
module debounce_pulse
   import sw_value_capture_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
   input  logic CLK,
   input  logic RST,
   input  logic raw,
   output logic level,
   output logic press
);

   localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   sync_lvl;
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic                   db_q, db_d;
   logic                   db_prev_q;
   logic                   press_q, press_d;

   assign sync_lvl = sync_q[SYNC_STAGES-1];
   assign level    = db_q;
   assign press    = press_q;

   // Debounce counter: a level change is accepted only after it persists.
   always_comb begin
      cnt_d   = cnt_q;
      db_d    = db_q;
      press_d = db_q & ~db_prev_q;
      if (sync_lvl != db_q) begin
         if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
            db_d  = sync_lvl;
            cnt_d = '0;
         end else begin
            cnt_d = cnt_q + CNT_W'(1);
         end
      end else begin
         cnt_d = '0;
      end
   end

   // Synchronizer, debounce state and rising-edge detect registers.
   always_ff @(posedge CLK) begin
      if (RST) begin
         sync_q    <= '0;
         cnt_q     <= '0;
         db_q      <= 1'b0;
         db_prev_q <= 1'b0;
         press_q   <= 1'b0;
      end else begin
         sync_q    <= {sync_q[SYNC_STAGES-2:0], raw};
         cnt_q     <= cnt_d;
         db_q      <= db_d;
         db_prev_q <= db_q;
         press_q   <= press_d;
      end
   end

endmodule : debounce_pulse

// File: rtl/sw_value_capture.sv
// Packs four debounced switch-byte captures into a 32-bit value with a one-cycle strobe.
module sw_value_capture
   import sw_value_capture_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
   input  logic               CLK,
   input  logic               RST,
   sw_value_capture_if.slave  bus
);

   logic [BYTE_W-1:0]     sw_pipe_q [SYNC_STAGES];
   logic [BYTE_W-1:0]     sw_sync;
   logic                  ld_press, clr_press;
   logic                  ld_level_unused, clr_level_unused;
   logic [BYTE_CNT_W-1:0] cnt_q, cnt_d;
   logic [PARTIAL_W-1:0]  partial_q, partial_d;
   logic [WORD_W-1:0]     value_q, value_d;
   logic                  enable_q, enable_d;

   assign sw_sync      = sw_pipe_q[SYNC_STAGES-1];
   assign bus.value    = value_q;
   assign bus.enable   = enable_q;
   assign bus.byte_cnt = cnt_q;

   debounce_pulse #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_load (
      .CLK   (CLK),
      .RST   (RST),
      .raw   (bus.btn_load),
      .level (ld_level_unused),
      .press (ld_press)
   );

   debounce_pulse #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_clr (
      .CLK   (CLK),
      .RST   (RST),
      .raw   (bus.btn_clr),
      .level (clr_level_unused),
      .press (clr_press)
   );

   // Switch synchronizer.
   always_ff @(posedge CLK) begin
      if (RST) begin
         for (int unsigned i = 0; i < SYNC_STAGES; i++) sw_pipe_q[i] <= '0;
      end else begin
         sw_pipe_q[0] <= bus.sw;
         for (int unsigned i = 1; i < SYNC_STAGES; i++) sw_pipe_q[i] <= sw_pipe_q[i-1];
      end
   end

   // Packing next-state: clear beats load; the last byte completes the word.
   always_comb begin
      cnt_d     = cnt_q;
      partial_d = partial_q;
      value_d   = value_q;
      enable_d  = 1'b0;
      if (clr_press) begin
         cnt_d = '0;
      end else if (ld_press) begin
         if (cnt_q == BYTE_CNT_W'(BYTES_PER_WORD - 1)) begin
            value_d  = {sw_sync, partial_q};
            enable_d = 1'b1;
            cnt_d    = '0;
         end else begin
            for (int unsigned k = 0; k < BYTES_PER_WORD - 1; k++) begin
               if (cnt_q == BYTE_CNT_W'(k)) partial_d[k*BYTE_W +: BYTE_W] = sw_sync;
            end
            cnt_d = cnt_q + BYTE_CNT_W'(1);
         end
      end
   end

   // Packing state and output registers.
   always_ff @(posedge CLK) begin
      if (RST) begin
         cnt_q     <= '0;
         partial_q <= '0;
         value_q   <= '0;
         enable_q  <= 1'b0;
      end else begin
         cnt_q     <= cnt_d;
         partial_q <= partial_d;
         value_q   <= value_d;
         enable_q  <= enable_d;
      end
   end

endmodule : sw_value_capture

// File: tb/tb_sw_value_capture.sv
// Directed bench for sw_value_capture with DEBOUNCE_CYCLES = 4.
module tb_sw_value_capture;

   logic CLK = 1'b0;
   logic RST = 1'b1;
   int   checks = 0;
   int   errors = 0;
   int   en_cnt, en_at;

   sw_value_capture_if bus ();

   sw_value_capture #(.DEBOUNCE_CYCLES(4)) dut (
      .CLK (CLK),
      .RST (RST),
      .bus (bus)
   );

   always #5 CLK = ~CLK;

   // Advance one rising edge, then settle 1 time unit past it.
   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   // Present sw, hold the button(s) for 8 edges, release, and record strobe timing.
   // en_at is the edge index after raw rise: edge E is index 1, so E+7 is index 8.
   task automatic press_btn(input logic ld, input logic clr, input logic [7:0] v,
                            output int n_en, output int at_en);
      n_en  = 0;
      at_en = 0;
      bus.sw = v;
      tick();
      tick();
      bus.btn_load = ld;
      bus.btn_clr  = clr;
      for (int i = 1; i <= 20; i++) begin
         tick();
         if (bus.enable === 1'b1) begin
            n_en++;
            at_en = i;
         end
         if (i == 8) begin
            bus.btn_load = 1'b0;
            bus.btn_clr  = 1'b0;
         end
      end
   endtask

   initial begin
      logic [7:0] seq1 [4];
      logic [7:0] seqa [4];
      seq1 = '{8'h11, 8'h22, 8'h33, 8'h44};
      seqa = '{8'hA0, 8'hA1, 8'hA2, 8'hA3};
      bus.sw       = 8'h00;
      bus.btn_load = 1'b0;
      bus.btn_clr  = 1'b0;

      // Reset, then idle
      RST = 1'b1;
      repeat (3) tick();
      RST = 1'b0;
      check("rst_value", bus.value, 32'h0);
      check("rst_enable", 32'(bus.enable), 32'h0);
      check("rst_byte_cnt", 32'(bus.byte_cnt), 32'h0);
      begin
         int idle_en = 0;
         for (int i = 0; i < 10; i++) begin
            tick();
            if (bus.enable !== 1'b0 || bus.byte_cnt !== 2'd0 || bus.value !== 32'h0) idle_en++;
         end
         check("idle_quiet", 32'(idle_en), 32'h0);
      end

      // First word
      for (int b = 0; b < 4; b++) begin
         press_btn(1'b1, 1'b0, seq1[b], en_cnt, en_at);
         check($sformatf("w1_cnt%0d", b), 32'(bus.byte_cnt), 32'((b + 1) % 4));
         check($sformatf("w1_en_n%0d", b), 32'(en_cnt), (b == 3) ? 32'd1 : 32'd0);
      end
      check("w1_en_at", 32'(en_at), 32'd8);
      check("w1_value", bus.value, 32'h44332211);

      // Bounces of 1, 2, 3 cycles must not capture
      bus.sw = 8'h5A;
      tick();
      tick();
      for (int h = 1; h <= 3; h++) begin
         bus.btn_load = 1'b1;
         repeat (h) tick();
         bus.btn_load = 1'b0;
         repeat (2) tick();
      end
      repeat (8) tick();
      check("bounce_cnt0", 32'(bus.byte_cnt), 32'h0);
      press_btn(1'b1, 1'b0, 8'h5A, en_cnt, en_at);
      check("bounce_cnt1", 32'(bus.byte_cnt), 32'h1);

      // Second byte, then clear
      press_btn(1'b1, 1'b0, 8'h77, en_cnt, en_at);
      check("pre_clr_cnt", 32'(bus.byte_cnt), 32'h2);
      press_btn(1'b0, 1'b1, 8'h99, en_cnt, en_at);
      check("clr_cnt", 32'(bus.byte_cnt), 32'h0);
      check("clr_no_en", 32'(en_cnt), 32'h0);
      check("clr_value_kept", bus.value, 32'h44332211);

      // Word after clear
      for (int b = 0; b < 4; b++) begin
         press_btn(1'b1, 1'b0, seqa[b], en_cnt, en_at);
         if (b < 3) check($sformatf("wa_hold%0d", b), bus.value, 32'h44332211);
      end
      check("wa_en_n", 32'(en_cnt), 32'd1);
      check("wa_en_at", 32'(en_at), 32'd8);
      check("wa_value", bus.value, 32'hA3A2A1A0);

      // Simultaneous load and clear at byte_cnt = 3
      press_btn(1'b1, 1'b0, 8'hB0, en_cnt, en_at);
      press_btn(1'b1, 1'b0, 8'hB1, en_cnt, en_at);
      press_btn(1'b1, 1'b0, 8'hB2, en_cnt, en_at);
      check("both_pre_cnt", 32'(bus.byte_cnt), 32'h3);
      press_btn(1'b1, 1'b1, 8'hB3, en_cnt, en_at);
      check("both_cnt", 32'(bus.byte_cnt), 32'h0);
      check("both_no_en", 32'(en_cnt), 32'h0);
      check("both_value", bus.value, 32'hA3A2A1A0);
      for (int b = 0; b < 4; b++) press_btn(1'b1, 1'b0, 8'(8'hC0 + b), en_cnt, en_at);
      check("after_both_value", bus.value, 32'hC3C2C1C0);

      // Reset mid-word and mid-debounce, button kept held through and after reset
      press_btn(1'b1, 1'b0, 8'hD0, en_cnt, en_at);
      press_btn(1'b1, 1'b0, 8'hD1, en_cnt, en_at);
      check("rst2_pre_cnt", 32'(bus.byte_cnt), 32'h2);
      bus.sw = 8'hD2;
      tick();
      tick();
      bus.btn_load = 1'b1;
      repeat (4) tick();
      RST = 1'b1;
      tick();
      check("rst2_value", bus.value, 32'h0);
      check("rst2_enable", 32'(bus.enable), 32'h0);
      check("rst2_cnt", 32'(bus.byte_cnt), 32'h0);
      RST = 1'b0;
      repeat (7) tick();
      check("held_no_early", 32'(bus.byte_cnt), 32'h0);
      tick();
      check("held_fresh_press", 32'(bus.byte_cnt), 32'h1);
      repeat (10) tick();
      check("held_single", 32'(bus.byte_cnt), 32'h1);
      bus.btn_load = 1'b0;
      repeat (10) tick();
      for (int b = 1; b < 4; b++) press_btn(1'b1, 1'b0, 8'(8'hE0 + b), en_cnt, en_at);
      check("rst2_word", bus.value, 32'hE3E2E1D2);
      check("rst2_word_en", 32'(en_cnt), 32'd1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule : tb_sw_value_capture
